edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_arb_pkg.sv | 12 +
 rtl/rising_edge_vec.sv | 26 ++
 rtl/edge_event_arbiter.sv | 154 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: FSM states and channel-count bounds.
package edge_arb_pkg;

    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rising_edge_vec.sv
// Per-bit rising-edge detector; the delayed copy resets to 0 so a bit held high
// through reset release is reported as an edge on the first clock.
module rising_edge_vec
    import edge_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] p1_sig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_sig <= '0;
        end else begin
            p1_sig <= sig;
        end
    end

    assign rise = sig & ~p1_sig;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges on NUM_CH level inputs and hands them out one at a time, round-robin,
// over a valid/ready port. Overrun tracking is compiled in only with EDGE_ARB_OVERRUN_EN.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] evt_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    input  logic              clear_overrun
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("edge_event_arbiter: NUM_CH outside supported range");
    end

    arb_state_t        state;
    arb_state_t        state_next;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr_mask;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_sel;
    logic              grant_load;
    logic              ptr_advance;
    logic              handshake;

    // Lowest requesting index at or above ptr, otherwise lowest requesting index overall.
    function automatic logic [ID_W-1:0] rr_select(input logic [NUM_CH-1:0] req,
                                                  input logic [ID_W-1:0]   ptr);
        logic [ID_W-1:0] hi_pick;
        logic [ID_W-1:0] any_pick;
        logic            hi_found;
        hi_pick  = '0;
        any_pick = '0;
        hi_found = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req[j]) begin
                any_pick = ID_W'(j);
                if (j >= int'(ptr)) begin
                    hi_pick  = ID_W'(j);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi_pick : any_pick;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_CH - 1)) ? '0 : id + ID_W'(1);
    endfunction

    rising_edge_vec #(
        .WIDTH (NUM_CH)
    ) u_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (evt_in),
        .rise  (rise)
    );

    assign grant_sel = rr_select(pending, rr_ptr);
    assign handshake = evt_valid & evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        evt_valid   = 1'b0;
        grant_load  = 1'b0;
        ptr_advance = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    grant_load = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    ptr_advance = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (handshake) begin
            clr_mask[evt_id] = 1'b1;
        end
    end

    // A fresh edge on the channel being retired keeps it pending, so rise is ORed in last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant_load) begin
                evt_id <= grant_sel;
            end
            if (ptr_advance) begin
                rr_ptr <= next_ptr(evt_id);
            end
        end
    end

`ifdef EDGE_ARB_OVERRUN_EN
    logic [NUM_CH-1:0] overrun_set;

    assign overrun_set = rise & pending & ~clr_mask;

    // Setting takes priority over the global clear so no loss goes unreported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= '0;
        end else if (clear_overrun) begin
            overrun <= overrun_set;
        end else begin
            overrun <= overrun | overrun_set;
        end
    end
`else
    logic unused_clear_overrun;

    assign unused_clear_overrun = clear_overrun;
    assign overrun              = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a queue/array reference model.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  evt_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [N-1:0]  pending;
    logic [N-1:0]  overrun;
    logic          clear_overrun;

    int checks   = 0;
    int failures = 0;

    bit m_p1   [N];
    bit m_pend [N];
    bit m_ovr  [N];
    int m_ptr;
    bit m_offer;
    int m_id;
    int grant_log[$];

    edge_event_arbiter #(
        .NUM_CH (N),
        .ID_W   (ID_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .evt_in        (evt_in),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_id        (evt_id),
        .pending       (pending),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] ein, input logic rdy, input logic clr);
        evt_in        = ein;
        evt_ready     = rdy;
        clear_overrun = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic int log_at(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_p1[i]   = 1'b0;
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
        m_ptr   = 0;
        m_offer = 1'b0;
        m_id    = 0;
    endtask

    // Event bookkeeping: an edge is a 0->1 step versus the last sampled level; the grant
    // scans channels starting at the pointer and wraps with modulo arithmetic.
    task automatic model_step();
        bit new_pend[N];
        bit hs;
        bit rise;
        bit retired;
        bit found;
        int idx;
        hs = m_offer && evt_ready;
        for (int i = 0; i < N; i++) begin
            rise    = evt_in[i] && !m_p1[i];
            retired = hs && (m_id == i);
`ifdef EDGE_ARB_OVERRUN_EN
            if (rise && m_pend[i] && !retired) m_ovr[i] = 1'b1;
            else if (clear_overrun) m_ovr[i] = 1'b0;
`endif
            new_pend[i] = rise || (m_pend[i] && !retired);
        end
        if (!m_offer) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && m_pend[idx]) begin
                    found   = 1'b1;
                    m_id    = idx;
                    m_offer = 1'b1;
                end
            end
        end else if (hs) begin
            grant_log.push_back(m_id);
            m_ptr   = (m_id + 1) % N;
            m_offer = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = new_pend[i];
            m_p1[i]   = evt_in[i];
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("evt_valid", {31'd0, evt_valid}, {31'd0, m_offer});
            if (m_offer) checkOutput("evt_id", {30'd0, evt_id}, m_id);
            checkOutput("pending", {28'd0, pending}, {28'd0, pack(m_pend)});
            checkOutput("overrun", {28'd0, overrun}, {28'd0, pack(m_ovr)});
        end
    end

    initial begin
        logic [N-1:0] e;
        logic [N-1:0] ovr_exp;
`ifdef EDGE_ARB_OVERRUN_EN
        ovr_exp = 4'b1000;
`else
        ovr_exp = 4'b0000;
`endif
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {31'd0, evt_valid}, 0);
        checkOutput("rst_id", {30'd0, evt_id}, 0);
        checkOutput("rst_pending", {28'd0, pending}, 0);
        checkOutput("rst_overrun", {28'd0, overrun}, 0);
        reset = 1'b0;

        $display("[TB] simultaneous edges on 0,1,3");
        grant_log.delete();
        applyStimulus(4'b1011, 1'b1, 1'b0);
        repeat (7) tick();
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("wrap_valid", {31'd0, evt_valid}, 1);
        checkOutput("wrap_id", {30'd0, evt_id}, 0);
        tick();
        checkOutput("order_0", log_at(0), 0);
        checkOutput("order_1", log_at(1), 1);
        checkOutput("order_2", log_at(2), 3);
        checkOutput("order_3", log_at(3), 0);

        $display("[TB] single edge latency on channel 2");
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick();
        checkOutput("lat_pending", {28'd0, pending}, 4'b0100);
        checkOutput("lat_valid0", {31'd0, evt_valid}, 0);
        tick();
        checkOutput("lat_valid1", {31'd0, evt_valid}, 1);
        checkOutput("lat_id", {30'd0, evt_id}, 2);
        tick();
        checkOutput("lat_cleared", {28'd0, pending}, 0);
        checkOutput("lat_idle", {31'd0, evt_valid}, 0);

        $display("[TB] stalled offer of channel 1");
        grant_log.delete();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0110, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("stall_valid", {31'd0, evt_valid}, 1);
            checkOutput("stall_id", {30'd0, evt_id}, 1);
        end
        applyStimulus(4'b0110, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("stall_next_id", {30'd0, evt_id}, 2);
        tick();
        checkOutput("stall_log0", log_at(0), 1);
        checkOutput("stall_log1", log_at(1), 2);

        $display("[TB] repeated edge on pending channel 3");
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b1000, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_set", {28'd0, overrun}, {28'd0, ovr_exp});
        tick();
        checkOutput("ovr_hold", {28'd0, overrun}, {28'd0, ovr_exp});
        applyStimulus(4'b1000, 1'b0, 1'b1);
        tick();
        checkOutput("ovr_clear", {28'd0, overrun}, 0);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        repeat (3) tick();

        $display("[TB] edge coincident with handshake on channel 1");
        grant_log.delete();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick();
        checkOutput("coin_pending", {28'd0, pending}, 4'b0010);
        checkOutput("coin_valid0", {31'd0, evt_valid}, 0);
        tick();
        checkOutput("coin_valid1", {31'd0, evt_valid}, 1);
        checkOutput("coin_id", {30'd0, evt_id}, 1);
        tick();
        checkOutput("coin_cleared", {28'd0, pending}, 0);
        checkOutput("coin_log0", log_at(0), 1);
        checkOutput("coin_log1", log_at(1), 1);

        $display("[TB] asynchronous reset during offer");
        grant_log.delete();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, evt_valid}, 0);
        checkOutput("arst_pending", {28'd0, pending}, 0);
        checkOutput("arst_id", {30'd0, evt_id}, 0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("rel_pending", {28'd0, pending}, 4'b0001);
        tick();
        checkOutput("rel_valid", {31'd0, evt_valid}, 1);
        checkOutput("rel_id", {30'd0, evt_id}, 0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        tick();
        checkOutput("rel_log0", log_at(0), 0);
        checkOutput("rel_lost", grant_log.size(), 1);

        $display("[TB] randomised traffic");
        e = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) e[b] = ~e[b];
            end
            applyStimulus(e, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
